// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
//   Shared definitions for the instruction-fetch stage:
//     - FSM state encodings (S_REQ / S_HOLD)
//     - NOP instruction encoding
//     - default reset PC and legal instruction-memory window
//     - IF/ID payload struct and the fetch-window check helper
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

    // Fetch FSM state encodings
    localparam logic [0:0] S_REQ  = 1'b0;  // request / wait for memory
    localparam logic [0:0] S_HOLD = 1'b1;  // word captured while D was stalled

    // Instruction injected for bubbles and for faulting fetches
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Default reset PC and legal fetch window
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_SIZE  = 32'h0000_4000;

    // One IF/ID payload as produced by the fetch FSM
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        adel;
    } ifid_payload_t;

    // True when a fetch at pc must not go to memory: misaligned, or outside
    // [base, base+size). Compared in 33 bits so base+size cannot wrap.
    function automatic logic fetch_is_bad(
        input logic [31:0] pc,
        input logic [31:0] base,
        input logic [31:0] size
    );
        logic [32:0] pc_w;
        logic [32:0] lo_w;
        logic [32:0] hi_w;
        pc_w = {1'b0, pc};
        lo_w = {1'b0, base};
        hi_w = {1'b0, base} + {1'b0, size};
        return (pc[1:0] != 2'b00) || (pc_w < lo_w) || (pc_w >= hi_w);
    endfunction

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register with enable and bubble insertion.
//   Ports:
//     clk, reset        - clock, synchronous active-high reset
//     en                - register updates this cycle (D not stalled)
//     load              - a real instruction is available (else bubble)
//     ir_in/pc_in/adel_in - payload of the instruction being delivered
//     IR_D/PC_D/PC4_D/valid_D/adel_D - registered IF/ID contents
// ---------------------------------------------------------------------------
module if_id_reg
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] ir_in,
    input  logic [31:0] pc_in,
    input  logic        adel_in,
    output logic [31:0] IR_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC4_D,
    output logic        valid_D,
    output logic        adel_D
);

    logic [31:0] ir_q,  ir_d;
    logic [31:0] pc_q,  pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        adel_q,  adel_d;

    always_comb begin
        ir_d    = ir_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        adel_d  = adel_q;
        if (en) begin
            if (load) begin
                ir_d    = ir_in;
                pc_d    = pc_in;
                pc4_d   = pc_in + 32'd4;
                valid_d = 1'b1;
                adel_d  = adel_in;
            end else begin
                // Bubble: PC_D/PC4_D keep their last value on purpose so
                // D-stage next-PC logic never sees a meaningless address.
                ir_d    = NOP_INSTR;
                valid_d = 1'b0;
                adel_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q    <= NOP_INSTR;
            pc_q    <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            adel_q  <= adel_d;
        end
    end

    assign IR_D    = ir_q;
    assign PC_D    = pc_q;
    assign PC4_D   = pc4_q;
    assign valid_D = valid_q;
    assign adel_D  = adel_q;

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage of a 5-stage MIPS pipeline. Holds PC_F, issues
//   word fetches over a req/ready handshake, registers each word into IF/ID
//   and follows D-stage branch/jump targets after the delay slot.
//   Ports:
//     clk, reset          - clock, synchronous active-high reset
//     stall_D             - hold IF/ID and PC_F
//     redirect/npc_target - taken control transfer from D and its target
//     imem_req/imem_addr  - fetch request and byte address (= PC_F)
//     imem_rdata/imem_ready - fetched word and completion strobe
//     IR_D/PC_D/PC4_D/valid_D/adel_D - IF/ID register outputs
// ---------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
    parameter logic [31:0] IM_SIZE  = DEF_IM_SIZE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_D,
    input  logic        redirect,
    input  logic [31:0] npc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IR_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC4_D,
    output logic        valid_D,
    output logic        adel_D
);

    logic [0:0]  state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] hold_q,       hold_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_tgt_q,   pend_tgt_d;

    logic          fetch_bad;
    logic          avail;
    logic          advance;
    ifid_payload_t deliver;

    // A bad PC never reaches memory; the fault itself counts as the
    // "fetched" item so the pipeline can carry adel_D to the exception logic.
    assign fetch_bad = fetch_is_bad(pc_q, IM_BASE, IM_SIZE);
    assign imem_req  = (state_q == S_REQ) && !fetch_bad;
    assign imem_addr = pc_q;
    assign avail     = (imem_req && imem_ready) || fetch_bad;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        pend_valid_d = pend_valid_q;
        pend_tgt_d   = pend_tgt_q;
        advance      = 1'b0;
        deliver.ir   = NOP_INSTR;
        deliver.pc   = pc_q;
        deliver.adel = 1'b0;

        if (state_q == S_REQ) begin
            if (avail) begin
                if (!stall_D) begin
                    advance      = 1'b1;
                    deliver.ir   = fetch_bad ? NOP_INSTR : imem_rdata;
                    deliver.adel = fetch_bad;
                end else if (!fetch_bad) begin
                    // Memory finished while D is stalled: park the word so
                    // the request can drop without losing it.
                    hold_d  = imem_rdata;
                    state_d = S_HOLD;
                end
                // avail on a bad PC during a stall: nothing to keep, the
                // fault is simply re-evaluated next cycle.
            end
        end else begin
            if (!stall_D) begin
                advance    = 1'b1;
                deliver.ir = hold_q;
                state_d    = S_REQ;
            end
        end

        // The word at PC_F is the delay slot and is always delivered; only
        // the PC after it follows the redirect. A redirect seen while the
        // slot has not been fetched yet is parked until the slot advances.
        if (advance) begin
            if (redirect) begin
                pc_d = npc_target;
            end else if (pend_valid_q) begin
                pc_d = pend_tgt_q;
            end else begin
                pc_d = pc_q + 32'd4;
            end
            pend_valid_d = 1'b0;
        end else if (!stall_D && redirect) begin
            pend_tgt_d   = npc_target;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            hold_q       <= NOP_INSTR;
            pend_valid_q <= 1'b0;
            pend_tgt_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_q       <= hold_d;
            pend_valid_q <= pend_valid_d;
            pend_tgt_q   <= pend_tgt_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .en      (!stall_D),
        .load    (advance),
        .ir_in   (deliver.ir),
        .pc_in   (deliver.pc),
        .adel_in (deliver.adel),
        .IR_D    (IR_D),
        .PC_D    (PC_D),
        .PC4_D   (PC4_D),
        .valid_D (valid_D),
        .adel_D  (adel_D)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//   Directed stimulus for if_fetch_unit. Every IF/ID update the stimulus
//   expects (instruction, fault or bubble) is queued up front; a monitor
//   pops one entry on each edge where IF/ID is enabled and compares it.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_D;
    logic        redirect;
    logic [31:0] npc_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] IR_D;
    logic [31:0] PC_D;
    logic [31:0] PC4_D;
    logic        valid_D;
    logic        adel_D;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall_D    (stall_D),
        .redirect   (redirect),
        .npc_target (npc_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .IR_D       (IR_D),
        .PC_D       (PC_D),
        .PC4_D      (PC4_D),
        .valid_D    (valid_D),
        .adel_D     (adel_D)
    );

    // Memory: the word is a fixed scramble of its address, and only valid
    // while a request completes; otherwise garbage is driven.
    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = (imem_req && imem_ready) ? w(imem_addr) : 32'hBAD0_BAD0;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        adel;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic push_ins(input logic [31:0] pc);
        exp_t e;
        e.valid = 1'b1; e.pc = pc; e.ir = w(pc); e.adel = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_adel(input logic [31:0] pc);
        exp_t e;
        e.valid = 1'b1; e.pc = pc; e.ir = 32'h0; e.adel = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_bub();
        exp_t e;
        e.valid = 1'b0; e.pc = 32'h0; e.ir = 32'h0; e.adel = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample 2 time units after the edge.
    task automatic step(input logic st, input logic rd, input logic [31:0] tgt, input logic rdy);
        stall_D    = st;
        redirect   = rd;
        npc_target = tgt;
        imem_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    // Monitor: IF/ID is written on every edge without reset or stall.
    logic mon_st;
    logic mon_rst;
    exp_t mon_e;
    logic mon_ok;

    always @(posedge clk) begin
        mon_st  = stall_D;
        mon_rst = reset;
        #1;
        if (!mon_rst && !mon_st) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL ifid_unexpected: got valid=%b pc=%h ir=%h, want no update (t=%0t)",
                         valid_D, PC_D, IR_D, $time);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_ok = (valid_D === mon_e.valid) && (IR_D === mon_e.ir) &&
                         (adel_D === mon_e.adel) &&
                         (!mon_e.valid || ((PC_D === mon_e.pc) && (PC4_D === mon_e.pc + 32'd4)));
                if (!mon_ok) begin
                    n_bad++;
                    $display("FAIL ifid: got valid=%b pc=%h pc4=%h ir=%h adel=%b, want valid=%b pc=%h ir=%h adel=%b (t=%0t)",
                             valid_D, PC_D, PC4_D, IR_D, adel_D,
                             mon_e.valid, mon_e.pc, mon_e.ir, mon_e.adel, $time);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; stall_D = 1'b0; redirect = 1'b0; npc_target = 32'h0; imem_ready = 1'b1;

        // Reset state
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("rst_valid", {31'h0, valid_D}, 32'h0);
        check("rst_ir",    IR_D,  32'h0);
        check("rst_pc",    PC_D,  32'h0);
        check("rst_pc4",   PC4_D, 32'h0);
        check("rst_adel",  {31'h0, adel_D}, 32'h0);
        check("rst_addr",  imem_addr, 32'h0000_3000);
        check("rst_req",   {31'h0, imem_req}, 32'h1);
        reset = 1'b0;

        // Zero-wait streaming
        push_ins(32'h3000); push_ins(32'h3004); push_ins(32'h3008);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Memory wait states: request held, two bubbles
        push_bub(); push_bub(); push_ins(32'h300C);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("wait_req1",  {31'h0, imem_req}, 32'h1);
        check("wait_addr1", imem_addr, 32'h300C);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("wait_req2",  {31'h0, imem_req}, 32'h1);
        check("wait_addr2", imem_addr, 32'h300C);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Stall while memory completes at 0x3010: hold buffer
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("hold_req",   {31'h0, imem_req}, 32'h0);
        check("hold_pc_d",  PC_D, 32'h300C);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("hold_req3",  {31'h0, imem_req}, 32'h0);
        check("hold_ir_d",  IR_D, w(32'h300C));
        push_ins(32'h3010); push_ins(32'h3014);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("post_hold_addr", imem_addr, 32'h3018);

        // Redirect: delay slot 0x3018 then target 0x3100
        push_ins(32'h3018); push_ins(32'h3100);
        step(1'b0, 1'b1, 32'h3100, 1'b1);
        check("redir_addr", imem_addr, 32'h3100);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect while slot 0x3104 waits on memory: pending target
        push_bub(); push_bub(); push_ins(32'h3104); push_ins(32'h3200);
        step(1'b0, 1'b1, 32'h3200, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("pend_slot_addr", imem_addr, 32'h3104);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("pend_tgt_addr", imem_addr, 32'h3200);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Faulting targets: misaligned, below window, above window
        push_ins(32'h3204);
        step(1'b0, 1'b1, 32'h3102, 1'b1);
        check("mis_req", {31'h0, imem_req}, 32'h0);
        push_adel(32'h3102);
        step(1'b0, 1'b1, 32'h2FFC, 1'b1);
        check("low_req", {31'h0, imem_req}, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("bad_stall_pc_d", PC_D, 32'h3102);
        check("bad_stall_adel", {31'h0, adel_D}, 32'h1);
        check("bad_stall_addr", imem_addr, 32'h2FFC);
        push_adel(32'h2FFC);
        step(1'b0, 1'b1, 32'h7000, 1'b1);
        check("high_req", {31'h0, imem_req}, 32'h0);
        push_adel(32'h7000);
        step(1'b0, 1'b1, 32'h3300, 1'b1);
        check("back_req", {31'h0, imem_req}, 32'h1);

        // Top of address space: PC4_D wraps to 0
        push_ins(32'h3300);
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        check("top_req", {31'h0, imem_req}, 32'h0);
        push_adel(32'hFFFF_FFFC);
        step(1'b0, 1'b1, 32'h3400, 1'b1);
        check("wrap_pc4", PC4_D, 32'h0);
        push_ins(32'h3400);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset in S_HOLD with a pending redirect
        push_bub();
        step(1'b0, 1'b1, 32'h3500, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("hold2_req", {31'h0, imem_req}, 32'h0);
        reset = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("rst2_valid", {31'h0, valid_D}, 32'h0);
        check("rst2_pc",    PC_D, 32'h0);
        check("rst2_addr",  imem_addr, 32'h0000_3000);
        check("rst2_req",   {31'h0, imem_req}, 32'h1);
        reset = 1'b0;
        push_ins(32'h3000); push_ins(32'h3004);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("rst2_next_addr", imem_addr, 32'h3008);

        check("queue_drained", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
